// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/response channel and decode-side instruction
// handoff for the fetch sequencer; master is the sequencer side.
interface pc_fetch_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            instr_valid;
   logic [XLEN-1:0] instr_data;
   logic [XLEN-1:0] instr_pc;
   logic            decode_ready;

   modport master (
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output instr_valid,
      output instr_data,
      output instr_pc,
      input  decode_ready
   );

   modport slave (
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  instr_valid,
      input  instr_data,
      input  instr_pc,
      output decode_ready
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// RV32I program counter and single-outstanding instruction fetch sequencer,
// with redirect/trap handling and a one-entry instruction buffer to decode.
module pc_load_reg #(
   parameter int unsigned   N       = 32,
   parameter logic [N-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);
   logic [N-1:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q_q <= RST_VAL;
      else if (load_i) q_q <= d_i;
   end

   assign q_o = q_q;
endmodule

module pc_fetch_sequencer #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redirect_valid_i,
   input  logic [XLEN-1:0]        redirect_target_i,
   output logic [XLEN-1:0]        pc_out_o,
   output logic                   trap_valid_o,
   output logic [XLEN-1:0]        trap_addr_o,
   pc_fetch_sequencer_if.master   fetch_if
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

   state_e          state_q, state_d;
   logic            drop_q, drop_d;
   logic            armed_q, armed_d;
   logic            pc_load;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] buf_data_q, buf_data_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic            trap_valid_q, trap_valid_d;
   logic [XLEN-1:0] trap_addr_q, trap_addr_d;
   logic            target_misaligned;
   logic [XLEN-1:0] redirect_pc;

   pc_load_reg #(
      .N       (XLEN),
      .RST_VAL (RESET_VECTOR)
   ) u_pc_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (pc_load),
      .d_i    (pc_d),
      .q_o    (pc_q)
   );

   assign target_misaligned = (redirect_target_i[1:0] != 2'b00);
   assign redirect_pc       = target_misaligned ? TRAP_VECTOR : redirect_target_i;

   always_comb begin
      state_d      = state_q;
      drop_d       = drop_q;
      armed_d      = armed_q;
      pc_load      = 1'b0;
      pc_d         = pc_q + XLEN'(4);
      buf_data_d   = buf_data_q;
      buf_pc_d     = buf_pc_q;
      trap_valid_d = redirect_valid_i && target_misaligned;
      trap_addr_d  = (redirect_valid_i && target_misaligned) ? redirect_target_i : trap_addr_q;

      if (redirect_valid_i) begin
         // A redirect overrides the normal flow; any fetch already handed to
         // memory is marked so its response is thrown away.
         pc_load = 1'b1;
         pc_d    = redirect_pc;
         case (state_q)
            S_REQ: begin
               if (fetch_if.imem_req_ready) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (fetch_if.imem_rsp_valid) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               // Stay a full cycle in IDLE after reset release before fetching.
               armed_d = 1'b1;
               if (armed_q) state_d = S_REQ;
            end
            S_REQ: begin
               if (fetch_if.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (fetch_if.imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     buf_data_d = fetch_if.imem_rsp_data;
                     buf_pc_d   = pc_q;
                     pc_load    = 1'b1;
                     state_d    = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (fetch_if.decode_ready) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         drop_q       <= 1'b0;
         armed_q      <= 1'b0;
         buf_data_q   <= '0;
         buf_pc_q     <= '0;
         trap_valid_q <= 1'b0;
         trap_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         drop_q       <= drop_d;
         armed_q      <= armed_d;
         buf_data_q   <= buf_data_d;
         buf_pc_q     <= buf_pc_d;
         trap_valid_q <= trap_valid_d;
         trap_addr_q  <= trap_addr_d;
      end
   end

   assign fetch_if.imem_req_valid = (state_q == S_REQ);
   assign fetch_if.imem_req_addr  = pc_q;
   assign fetch_if.instr_valid    = (state_q == S_HOLD) && !redirect_valid_i;
   assign fetch_if.instr_data     = buf_data_q;
   assign fetch_if.instr_pc       = buf_pc_q;
   assign pc_out_o                = pc_q;
   assign trap_valid_o            = trap_valid_q;
   assign trap_addr_o             = trap_addr_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus a randomized run
// checked against an instruction-stream model of the fetch unit.
module tb_pc_fetch_sequencer;
   localparam int unsigned XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] TV   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] pc_out;
   logic        trap_valid;
   logic [31:0] trap_addr;
   int          total = 0;
   int          bad = 0;

   pc_fetch_sequencer_if #(.XLEN(XLEN)) bus ();

   pc_fetch_sequencer #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .redirect_valid_i  (redirect_valid),
      .redirect_target_i (redirect_target),
      .pc_out_o          (pc_out),
      .trap_valid_o      (trap_valid),
      .trap_addr_o       (trap_addr),
      .fetch_if          (bus.master)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      redirect_valid     = 1'b0;
      redirect_target    = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.decode_ready   = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0 ||
          bus.instr_pc !== 32'h0 || trap_valid !== 1'b0 || trap_addr !== 32'h0 ||
          bus.imem_req_addr !== RV || pc_out !== RV) begin
         bad++;
         $display("FAIL reset_values req=%b iv=%b id=%h ip=%h tv=%b ta=%h addr=%h pc=%h exp all zero",
                  bus.imem_req_valid, bus.instr_valid, bus.instr_data, bus.instr_pc,
                  trap_valid, trap_addr, bus.imem_req_addr, pc_out);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      total++;
      if (bus.imem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_cycle req_valid=%b exp=0", bus.imem_req_valid);
      end
      tick();
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RV) begin
         bad++;
         $display("FAIL reset_first_req valid=%b addr=%h exp valid=1 addr=%h",
                  bus.imem_req_valid, bus.imem_req_addr, RV);
      end
   endtask

   task automatic test_free_run();
      for (int k = 0; k < 3; k++) begin
         bus.imem_req_ready = 1'b1;
         bus.decode_ready   = 1'b1;
         #1;
         total++;
         if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * k)) begin
            bad++;
            $display("FAIL free_req%0d valid=%b addr=%h exp addr=%h", k,
                     bus.imem_req_valid, bus.imem_req_addr, 32'(4 * k));
         end
         tick();
         bus.imem_req_ready = 1'b0;
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = memf(32'(4 * k));
         #1;
         total++;
         if (bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL free_no_comb%0d instr_valid=%b exp=0", k, bus.instr_valid);
         end
         tick();
         bus.imem_rsp_valid = 1'b0;
         #1;
         total++;
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k) || bus.instr_data !== memf(32'(4 * k))) begin
            bad++;
            $display("FAIL free_instr%0d valid=%b pc=%h data=%h exp pc=%h data=%h", k,
                     bus.instr_valid, bus.instr_pc, bus.instr_data, 32'(4 * k), memf(32'(4 * k)));
         end
         tick();
      end
   endtask

   task automatic test_hold_stall();
      apply_reset();
      tick();
      tick();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hCAFE_0001;
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.decode_ready   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (bus.instr_valid !== 1'b1 || bus.instr_data !== 32'hCAFE_0001 ||
             bus.imem_req_valid !== 1'b0 || pc_out !== 32'h4) begin
            bad++;
            $display("FAIL hold_stall%0d iv=%b data=%h req=%b pc=%h exp iv=1 data=cafe0001 req=0 pc=4",
                     i, bus.instr_valid, bus.instr_data, bus.imem_req_valid, pc_out);
         end
         tick();
      end
      bus.decode_ready = 1'b1;
      tick();
      #1;
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4) begin
         bad++;
         $display("FAIL hold_release valid=%b addr=%h exp valid=1 addr=4", bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_redirect_wait();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      redirect_valid     = 1'b1;
      redirect_target    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      tick();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid = 1'b0;
      #1;
      total++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
         bad++;
         $display("FAIL redirect_wait iv=%b req=%b addr=%h exp iv=0 req=1 addr=200",
                  bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr);
      end
      tick();
      #1;
      total++;
      if (bus.instr_valid !== 1'b0 || bus.instr_data === 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL redirect_drop iv=%b data=%h exp iv=0 and no deadbeef", bus.instr_valid, bus.instr_data);
      end
   endtask

   task automatic test_trap();
      redirect_valid  = 1'b1;
      redirect_target = 32'h202;
      #1;
      total++;
      if (trap_valid !== 1'b0) begin
         bad++;
         $display("FAIL trap_early trap_valid=%b exp=0", trap_valid);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      total++;
      if (trap_valid !== 1'b1 || trap_addr !== 32'h202 || bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== TV) begin
         bad++;
         $display("FAIL trap_pulse tv=%b ta=%h req=%b addr=%h exp tv=1 ta=202 req=1 addr=%h",
                  trap_valid, trap_addr, bus.imem_req_valid, bus.imem_req_addr, TV);
      end
      tick();
      total++;
      if (trap_valid !== 1'b0) begin
         bad++;
         $display("FAIL trap_once trap_valid=%b exp=0", trap_valid);
      end
   endtask

   task automatic test_wrap();
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid     = 1'b0;
      bus.imem_req_ready = 1'b1;
      #1;
      total++;
      if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin
         bad++;
         $display("FAIL wrap_req addr=%h exp=fffffffc", bus.imem_req_addr);
      end
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(32'hFFFF_FFFC);
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.decode_ready   = 1'b1;
      #1;
      total++;
      if (bus.instr_pc !== 32'hFFFF_FFFC || pc_out !== 32'h0) begin
         bad++;
         $display("FAIL wrap_pc instr_pc=%h pc=%h exp fffffffc/0", bus.instr_pc, pc_out);
      end
      tick();
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
         bad++;
         $display("FAIL wrap_next valid=%b addr=%h exp valid=1 addr=0", bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_back_to_back();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(32'h0);
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.decode_ready   = 1'b1;
      redirect_valid     = 1'b1;
      redirect_target    = 32'h40;
      #1;
      total++;
      if (bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_redirect_mask iv=%b exp=0", bus.instr_valid);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40 || bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_redirect_req req=%b addr=%h iv=%b exp req=1 addr=40 iv=0",
                  bus.imem_req_valid, bus.imem_req_addr, bus.instr_valid);
      end
      // Redirect on the same edge the request is accepted: that fetch is aborted.
      bus.imem_req_ready = 1'b1;
      redirect_valid     = 1'b1;
      redirect_target    = 32'h80;
      tick();
      redirect_valid     = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(32'h40);
      tick();
      bus.imem_rsp_valid = 1'b0;
      #1;
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h80 || bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL req_abort req=%b addr=%h iv=%b exp req=1 addr=80 iv=0",
                  bus.imem_req_valid, bus.imem_req_addr, bus.instr_valid);
      end
   endtask

   task automatic test_reset_midfetch();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      total++;
      if (pc_out !== RV || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL midfetch_reset pc=%h req=%b iv=%b exp pc=%h req=0 iv=0",
                  pc_out, bus.imem_req_valid, bus.instr_valid, RV);
      end
      tick();
      rst_n = 1'b1;
      tick();
      bus.imem_rsp_valid = 1'b0;
      #1;
      total++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL midfetch_late_rsp req=%b iv=%b exp 0/0", bus.imem_req_valid, bus.instr_valid);
      end
      tick();
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
         bad++;
         $display("FAIL midfetch_first_req valid=%b addr=%h exp valid=1 addr=0", bus.imem_req_valid, bus.imem_req_addr);
      end
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(32'h0);
      tick();
      bus.imem_rsp_valid = 1'b0;
      #1;
      total++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr_data !== memf(32'h0)) begin
         bad++;
         $display("FAIL midfetch_refetch iv=%b pc=%h data=%h exp iv=1 pc=0 data=%h",
                  bus.instr_valid, bus.instr_pc, bus.instr_data, memf(32'h0));
      end
   endtask

   // Model: decode must see consecutive words starting at the latest redirect
   // destination (or the trap vector), each carrying memory contents.
   task automatic test_random(input int ncyc);
      logic [31:0] exp_pc, out_addr, tgt;
      logic        exp_trap, outstanding, redir, dec;
      logic [31:0] exp_trap_addr;
      int          lat, consumed;
      apply_reset();
      tick();
      tick();
      exp_pc        = RV;
      exp_trap      = 1'b0;
      exp_trap_addr = '0;
      outstanding   = 1'b0;
      out_addr      = '0;
      lat           = 0;
      consumed      = 0;
      for (int c = 0; c < ncyc; c++) begin
         bus.imem_req_ready = ($urandom % 4) != 0;
         dec   = 1'($urandom % 2);
         redir = ($urandom % 20) == 0;
         case ($urandom % 4)
            0, 1:    tgt = 32'($urandom % 1024) << 2;
            2:       tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            default: tgt = 32'hFFFF_FFFC;
         endcase
         bus.decode_ready = dec;
         redirect_valid   = redir;
         redirect_target  = tgt;
         if (outstanding && lat == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(out_addr);
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
            if (outstanding) lat--;
         end
         #1;
         total++;
         if (trap_valid !== exp_trap || (exp_trap && trap_addr !== exp_trap_addr)) begin
            bad++;
            $display("FAIL rnd_trap c=%0d tv=%b ta=%h exp tv=%b ta=%h", c, trap_valid, trap_addr, exp_trap, exp_trap_addr);
         end
         total++;
         if (bus.imem_req_valid === 1'b1 && outstanding) begin
            bad++;
            $display("FAIL rnd_outstanding c=%0d req_valid=1 exp=0 while fetch pending", c);
         end
         if (redir) begin
            total++;
            if (bus.instr_valid !== 1'b0) begin
               bad++;
               $display("FAIL rnd_redirect_mask c=%0d iv=%b exp=0", c, bus.instr_valid);
            end
         end
         if (bus.instr_valid === 1'b1 && dec) begin
            total++;
            if (bus.instr_pc !== exp_pc || bus.instr_data !== memf(exp_pc)) begin
               bad++;
               $display("FAIL rnd_instr c=%0d pc=%h data=%h exp pc=%h data=%h",
                        c, bus.instr_pc, bus.instr_data, exp_pc, memf(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         exp_trap      = redir && (tgt[1:0] != 2'b00);
         exp_trap_addr = tgt;
         if (redir) exp_pc = (tgt[1:0] != 2'b00) ? TV : tgt;
         if (bus.imem_rsp_valid) outstanding = 1'b0;
         if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
            outstanding = 1'b1;
            out_addr    = bus.imem_req_addr;
            lat         = $urandom_range(0, 2);
         end
         tick();
      end
      total++;
      if (consumed < 50) begin
         bad++;
         $display("FAIL rnd_progress consumed=%0d exp>=50", consumed);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_free_run();
      test_hold_stall();
      test_redirect_wait();
      test_trap();
      test_wrap();
      test_back_to_back();
      test_reset_midfetch();
      test_random(3000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the RV32I program counter and sequences instruction fetch from instruction memory.
- Holds the PC in the team's generic n-bit load register, chooses the next PC (sequential, redirect or trap), and runs the instruction-memory handshake with one request outstanding.
- Buffers one fetched instruction toward decode.
- Sits between the execute-stage redirect logic, instruction memory and decode.

Parameters:
XLEN, 32, PC and instruction width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned redirect

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  XLEN  redirect destination
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= current PC)
imem_rsp_valid  in  1  fetch data valid, single-cycle pulse
imem_rsp_data  in  XLEN  fetched instruction
instr_valid  out  1  buffered instruction valid to decode
instr_data  out  XLEN  buffered instruction
instr_pc  out  XLEN  PC of buffered instruction
decode_ready  in  1  decode consumes instruction
pc_out  out  XLEN  current PC
trap_valid  out  1  one-cycle misaligned-target trap pulse
trap_addr  out  XLEN  offending redirect_target

Behaviour:
- Reset: rst low forces state IDLE, PC=RESET_VECTOR and drop flag=0 immediately, independent of clk. Output values while rst is low: imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, trap_valid=0, trap_addr=0. imem_req_addr and pc_out track PC, so both read RESET_VECTOR.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after rst rises, then REQ.
- REQ: imem_req_valid=1, imem_req_addr=PC. Move to WAIT on the edge where imem_req_ready=1. The address is held stable until accepted, except when a redirect changes it.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - drop flag clear: register data into the buffer, instr_pc<=PC, PC<=PC+4, go HOLD.
  - drop flag set: discard data, clear the flag, go REQ.
- HOLD: instr_valid=1. On decode_ready=1, instr_valid drops next cycle and the state goes to REQ. The next request is issued one cycle after consumption; there is no overlap.
- Fetch latency: instr_valid rises exactly 1 cycle after the imem_rsp_valid edge.
- PC+4 wraps modulo 2^XLEN: 32'hFFFF_FFFC becomes 0.
- Redirect (redirect_valid=1, redirect_target[1:0]==0) has priority over everything except reset. Next-cycle effect by state:
  - IDLE/REQ: PC<=target, state REQ. A REQ handshake completing in the same cycle is treated as aborted: drop flag set, state WAIT.
  - WAIT: PC<=target, drop flag set. If imem_rsp_valid arrives in the same cycle, discard it and go REQ with the flag clear.
  - HOLD: buffer invalidated, PC<=target, state REQ.
- While redirect_valid=1, instr_valid is combinationally forced 0. The buffered instruction is never handed to decode in a redirect cycle, even if decode_ready=1.
- Misaligned redirect (target[1:0]!=0) is handled as a redirect to TRAP_VECTOR. Next cycle: trap_valid=1 for one cycle and trap_addr=target.
- Simultaneous redirect and response with drop flag clear: redirect wins and the response is discarded.
- rst low mid-fetch aborts immediately. A late imem_rsp_valid arriving in IDLE is ignored.
- No combinational path from imem_rsp_* to instr_*. instr_valid depends combinationally only on state and redirect_valid.

Test Plan:
- Reset then free-running fetch (imem_req_ready=1, rsp 1 cycle after accept, decode_ready=1) -> request addresses 0x0, 0x4, 0x8; instr_pc matches; instr_valid 1 cycle after each rsp.
- decode_ready held 0 for 5 cycles in HOLD -> instr_valid stays 1, instr_data stable, imem_req_valid stays 0, PC=0x4 throughout.
- redirect_valid to 0x200 in WAIT, rsp 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on instr_valid; next request addr=0x200.
- redirect to 0x202 -> trap_valid pulses once with trap_addr=0x202; next request addr=0x100.
- Redirect to 0xFFFF_FFFC followed by a completed fetch -> next request addr=0x0.
- rst low while in WAIT, with rsp arriving during reset and 1 cycle after release -> both ignored; first request addr=0x0 two cycles after release.
